vga_timing: RTL
===============

Name: vga_timing

Overview:
- Source of the vga_if timing bus: generates hcount/vcount, hsync/vsync and hblnk/vblnk for the 1024x768 @ 60 Hz raster (65 MHz pixel clock).
- Drives the vga_in port of the first draw stage (background drawer); downstream stages pipeline the bus unchanged.
- Also supplies a one-cycle frame-start strobe and a free-running frame counter for game-logic pacing (animation ticks, level transitions).

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, horizontal sync width (clocks)
- H_BP, 160, horizontal back porch (clocks); H_TOTAL = sum = 1344
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 29, vertical back porch (lines); V_TOTAL = sum = 806
- SYNC_ACTIVE, 1'b0, asserted level of hsync/vsync; inactive level = ~SYNC_ACTIVE

Ports:
- clk  in  1  pixel clock, 65 MHz
- rst  in  1  synchronous reset, active-high
- en  in  1  count enable; 0 freezes the raster
- vga_out  vga_if.out  -  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0]
- frame_start  out  1  one-cycle strobe at start of each new frame
- frame_cnt  out  8  frames completed since reset, modulo 256

Behaviour:
- Reset: synchronous reset, active-high (rst); clock clk.
- Reset values:
  - hcount = 0, vcount = 0
  - hblnk = 0, vblnk = 0
  - hsync = vsync = ~SYNC_ACTIVE
  - rgb = 0, frame_start = 0, frame_cnt = 0
- rst overrides en and takes effect on the next edge, including mid-line or mid-sync.
- Counters, per rising edge with en = 1:
  - hcount increments; at H_TOTAL-1 it wraps to 0.
  - vcount increments only on the hcount wrap; at V_TOTAL-1 (with hcount wrapping) it wraps to 0.
- en = 0: all outputs hold their values; frame_start forced to 0.
- Every output is registered and decoded from the next-state count values, so the decoded signals on a given cycle always match the hcount/vcount shown on that cycle. There is no skew between fields, and latency relative to the counter is 0.
- Decode (h = hcount, v = vcount, ranges inclusive-exclusive):
  - hblnk = (h >= H_ACTIVE)
  - hsync = SYNC_ACTIVE when h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 1048..1183
  - vblnk = (v >= V_ACTIVE)
  - vsync = SYNC_ACTIVE when v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. 771..776
  - vsync and vblnk change on the same cycle as vcount, i.e. at h = 0.
- rgb is driven constant 0; draw stages overwrite it.
- frame_start:
  - Asserted for exactly one cycle, coincident with outputs showing h = 0, v = 0, when reached by wrap from (H_TOTAL-1, V_TOTAL-1).
  - Not asserted on the first frame after reset.
- frame_cnt: increments on the same edge that asserts frame_start; wraps 255 -> 0.
- Widths: all count arithmetic is 11-bit unsigned. Parameters must satisfy H_TOTAL, V_TOTAL <= 2048, each porch >= 1 and each sync >= 1. No behaviour is defined outside these limits.

Test Plan:
- Reset then en = 1 for 1344 cycles -> hcount steps 0..1343 and returns to 0; vcount 0 -> 1 on the wrap cycle; hblnk rises at h = 1024; hsync low exactly for h = 1048..1183 (136 cycles).
- Run 806x1344 = 1,083,264 cycles -> vblnk = 1 for v = 768..805; vsync low for v = 771..776; frame_start pulses once at the wrap; frame_cnt = 1.
- Toggle en = 0 for 50 cycles at h = 500, v = 10 -> all outputs frozen; on resume the next value is h = 501; total frame length extends by exactly 50 cycles.
- Assert rst for 1 cycle at h = 1100, v = 772 (inside both syncs) -> next cycle h = 0, v = 0, hsync = vsync = 1, blanks 0, frame_cnt = 0, no frame_start.
- Run 257 frames -> frame_cnt reads 1 after wrap 255 -> 0 -> 1; frame_start count equals 257.
- Instantiate with SYNC_ACTIVE = 1 -> hsync/vsync high on the same ranges as above, low at reset.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_if: raster timing bus passed between draw stages.
//   hcount/vcount : current pixel position (11-bit)
//   hsync/vsync   : sync pulses, polarity set by the timing source
//   hblnk/vblnk   : high outside the visible area
//   rgb           : 12-bit pixel colour, written by draw stages
// Modport 'out' is used by the bus source, 'in' by a consuming stage.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out (
    output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );

  modport in (
    input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
  );
endinterface

// File: rtl/vga_timing.sv
// vga_timing: raster timing source for the VGA draw pipeline.
// Generates hcount/vcount, sync and blanking for a configurable raster
// (default 1024x768 @ 60 Hz, 65 MHz pixel clock), plus a frame-start strobe
// and a free-running 8-bit frame counter for game-logic pacing.
//
// Ports:
//   clk         in   pixel clock
//   rst         in   synchronous reset, active-high (overrides en)
//   en          in   count enable; 0 freezes every output (frame_start -> 0)
//   vga_out     out  timing bus (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb=0)
//   frame_start out  one-cycle strobe when the raster wraps to (0,0)
//   frame_cnt   out  frames completed since reset, modulo 256
module vga_timing #(
  parameter int   H_ACTIVE    = 1024,
  parameter int   H_FP        = 24,
  parameter int   H_SYNC      = 136,
  parameter int   H_BP        = 160,
  parameter int   V_ACTIVE    = 768,
  parameter int   V_FP        = 3,
  parameter int   V_SYNC      = 6,
  parameter int   V_BP        = 29,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  vga_if.out         vga_out,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLANK    = 11'(H_ACTIVE);
  localparam logic [10:0] V_BLANK    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;

  logic h_wrap;
  logic frame_wrap;

  // Next-state counts first, then every decoded field is derived from those
  // next-state counts so all registered outputs line up with the registered
  // counts on the same cycle.
  always_comb begin
    h_wrap        = (hcount_q == H_LAST);
    frame_wrap    = h_wrap && (vcount_q == V_LAST);

    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (en) begin
      hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
      if (h_wrap) begin
        vcount_d = (vcount_q == V_LAST) ? 11'd0 : vcount_q + 11'd1;
      end
      // Only a genuine wrap from the last pixel starts a counted frame;
      // the first frame after reset is entered via reset, not via wrap.
      if (frame_wrap) begin
        frame_start_d = 1'b1;
        frame_cnt_d   = frame_cnt_q + 8'd1;
      end
    end

    hblnk_d = (hcount_d >= H_BLANK);
    vblnk_d = (vcount_d >= V_BLANK);
    hsync_d = ((hcount_d >= HS_START) && (hcount_d < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vsync_d = ((vcount_d >= VS_START) && (vcount_d < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  // Background colour is black; later draw stages overwrite rgb.
  assign vga_out.rgb    = 12'd0;

  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
